// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: frame sequencer for the 2x2-kernel / 3x3-feature convolution
// datapath. It fetches 4 weights once per frame, then for each of the four
// outputs c11..c22 it fetches the matching 2x2 feature window and fires one
// accumulate cycle that routes all four lane products to that output.
//
// Handshake: start is a level request. It is sampled only in IDLE, and a frame
// begins on the first IDLE cycle that has start=1 and abort=0. busy covers every
// non-IDLE cycle. done is a single-cycle pulse that marks the DONE state. abort
// wins over everything: the next cycle is IDLE with no pending load enables.
module conv_seq_ctrl #(
  parameter int          ADDR_W = 8,
  parameter int unsigned W_BASE = 0,
  parameter int unsigned F_BASE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        weight_en,
  output logic [3:0]        feature_en,
  output logic [3:0]        buff_mux_sel,
  output logic [7:0]        sel_demux,
  output logic [3:0]        acc_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_F = 3'd2,
    S_WAIT   = 3'd3,
    S_ACC    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] W_BASE_A = ADDR_W'(W_BASE);
  localparam logic [ADDR_W-1:0] F_BASE_A = ADDR_W'(F_BASE);

  state_t     state, state_next;
  logic [1:0] k, k_next;       // lane counter, 0..3 selects lanes 1..4
  logic [1:0] o, o_next;       // output index, 0=c11 .. 3=c22
  logic       rd_weight;       // the read issued this cycle is a weight read

  // Load pipeline: remembers which read was issued last cycle so that the
  // matching lane register captures data_in when it arrives.
  logic       pipe_v;
  logic       pipe_w;
  logic [1:0] pipe_k;

  // Feature window offset: row (i + k[1]) and column (j + k[0]) inside the 3x3 map.
  logic [1:0] f_row;
  logic [1:0] f_col;
  logic [3:0] f_off;

  // Position of the feature word for output o, lane k.
  always_comb begin
    f_row = {1'b0, o[1]} + {1'b0, k[1]};
    f_col = {1'b0, o[0]} + {1'b0, k[0]};
    f_off = (4'(f_row) * 4'd3) + 4'(f_col);
  end

  // State, lane counter and output index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= 2'd0;
      o     <= 2'd0;
    end else begin
      state <= state_next;
      k     <= k_next;
      o     <= o_next;
    end
  end

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    state_next   = state;
    k_next       = k;
    o_next       = o;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    rd_weight    = 1'b0;
    buff_mux_sel = 4'b0000;
    sel_demux    = 8'h00;
    acc_en       = 4'b0000;
    busy         = (state != S_IDLE);
    done         = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_next = S_LOAD_W;
          k_next     = 2'd0;
          o_next     = 2'd0;
        end
      end
      S_LOAD_W: begin
        mem_rd_en = 1'b1;
        rd_weight = 1'b1;
        mem_addr  = W_BASE_A + ADDR_W'(k);
        k_next    = k + 2'd1;
        if (k == 2'd3) begin
          state_next = S_LOAD_F;
          k_next     = 2'd0;
        end
      end
      S_LOAD_F: begin
        mem_rd_en = 1'b1;
        mem_addr  = F_BASE_A + ADDR_W'(f_off);
        k_next    = k + 2'd1;
        if (k == 2'd3) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Last feature word is being captured by its lane this cycle.
        state_next = S_ACC;
      end
      S_ACC: begin
        buff_mux_sel = 4'b1111;
        sel_demux    = {4{o}};
        acc_en       = 4'b1000 >> o;
        if (o == 2'd3) begin
          state_next = S_DONE;
        end else begin
          o_next     = o + 2'd1;
          k_next     = 2'd0;
          state_next = S_LOAD_F;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (abort) begin
      state_next = S_IDLE;
      k_next     = 2'd0;
      o_next     = 2'd0;
    end
  end

  // Register the read that was just issued; abort drops it so no lane loads afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= 1'b0;
      pipe_w <= 1'b0;
      pipe_k <= 2'd0;
    end else begin
      pipe_v <= mem_rd_en && !abort;
      pipe_w <= rd_weight;
      pipe_k <= k;
    end
  end

  // One lane-enable bit per returning word; weights and features never collide.
  always_comb begin
    weight_en  = 4'b0000;
    feature_en = 4'b0000;
    if (pipe_v) begin
      if (pipe_w) begin
        weight_en = 4'b1000 >> pipe_k;
      end else begin
        feature_en = 4'b1000 >> pipe_k;
      end
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: a behavioural model of the datapath (memory with
// one-cycle read latency, per-lane weight/feature registers, four accumulators)
// hangs off the controller outputs. A cycle-indexed frame timeline and the 2x2
// convolution formula give the expected values.
module tb_conv_seq_ctrl;
  localparam int ADDR_W = 8;
  localparam int W_BASE = 0;
  localparam int F_BASE = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        weight_en;
  logic [3:0]        feature_en;
  logic [3:0]        buff_mux_sel;
  logic [7:0]        sel_demux;
  logic [3:0]        acc_en;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [3:0] we;
    logic [3:0] fe;
    logic [3:0] bm;
    logic [7:0] sd;
    logic [3:0] ae;
    logic       busy;
    logic       done;
  } out_t;

  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  conv_seq_ctrl #(.ADDR_W(ADDR_W), .W_BASE(W_BASE), .F_BASE(F_BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .weight_en(weight_en), .feature_en(feature_en),
    .buff_mux_sel(buff_mux_sel), .sel_demux(sel_demux), .acc_en(acc_en),
    .busy(busy), .done(done)
  );

  // ---------------- datapath model ----------------
  logic [7:0]  mem [0:255];
  logic [7:0]  rd_data;
  logic [7:0]  w_reg [0:3];
  logic [7:0]  f_reg [0:3];
  logic [31:0] acc [0:3];

  always @(posedge clk or posedge rst) begin
    logic [31:0] sum;
    if (rst) begin
      rd_data <= 8'h00;
      for (int l = 0; l < 4; l++) begin
        w_reg[l] <= 8'h00;
        f_reg[l] <= 8'h00;
        acc[l]   <= 32'd0;
      end
    end else begin
      if (mem_rd_en) rd_data <= mem[mem_addr];
      for (int l = 0; l < 4; l++) begin
        if (weight_en[3-l])  w_reg[l] <= rd_data;
        if (feature_en[3-l]) f_reg[l] <= rd_data;
      end
      for (int d = 0; d < 4; d++) begin
        if (acc_en[3-d]) begin
          sum = acc[d];
          for (int l = 0; l < 4; l++) begin
            if (buff_mux_sel[3-l] && (sel_demux[2*(3-l) +: 2] == 2'(d)))
              sum = sum + 32'(w_reg[l]) * 32'(f_reg[l]);
          end
          acc[d] <= sum;
        end
      end
    end
  end

  // ---------------- reference ----------------
  // Output o = (i,j): sum over kernel (a,b) of w[a][b] * f[i+a][j+b].
  function automatic logic [31:0] conv(int o);
    logic [31:0] s = 32'd0;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        s = s + 32'(mem[W_BASE + 2*a + b]) * 32'(mem[F_BASE + 3*(o/2 + a) + (o%2 + b)]);
    return s;
  endfunction

  // Frame timeline: cycle 0 samples start, 1..4 weight reads, then six cycles
  // per output (4 reads, wait, accumulate), done at 29.
  function automatic out_t exp_out(int c);
    out_t e = '0;
    int base;
    int kk;
    if (c >= 1 && c <= 29) e.busy = 1'b1;
    if (c >= 1 && c <= 4) begin
      e.rd   = 1'b1;
      e.addr = 8'(W_BASE + c - 1);
    end
    if (c >= 2 && c <= 5) e.we = 4'b1000 >> (c - 2);
    for (int o = 0; o < 4; o++) begin
      base = 5 + 6*o;
      if (c >= base && c <= base + 3) begin
        kk     = c - base;
        e.rd   = 1'b1;
        e.addr = 8'(F_BASE + 3*(o/2 + kk/2) + (o%2 + kk%2));
      end
      if (c >= base + 1 && c <= base + 4) e.fe = 4'b1000 >> (c - base - 1);
      if (c == base + 5) begin
        e.bm = 4'hf;
        e.sd = {4{2'(o)}};
        e.ae = 4'b1000 >> o;
      end
    end
    if (c == 29) e.done = 1'b1;
    return e;
  endfunction

  function automatic out_t obs_now();
    out_t r;
    r = {mem_rd_en, mem_addr, weight_en, feature_en, buff_mux_sel, sel_demux, acc_en, busy, done};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic load_nominal();
    for (int n = 0; n < 4; n++) mem[W_BASE + n] = 8'(n + 1);
    for (int n = 0; n < 9; n++) mem[F_BASE + n] = 8'(n + 1);
  endtask

  task automatic load_random();
    for (int n = 0; n < 13; n++) mem[n] = 8'($urandom_range(0, 255));
  endtask

  // Runs one frame from cycle 0 with full per-cycle and accumulator-progress checks.
  task automatic run_checked_frame(string name);
    out_t        e;
    out_t        ob;
    logic [31:0] ea;
    start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step();
      if (c == 1) start = 1'b0;
      e  = exp_out(c);
      ob = obs_now();
      total++;
      if (ob !== e) begin
        bad++;
        $display("FAIL %s outputs cycle %0d: got %h expected %h", name, c, ob, e);
      end
      for (int d = 0; d < 4; d++) begin
        ea = (c > 10 + 6*d) ? conv(d) : 32'd0;
        total++;
        if (acc[d] !== ea) begin
          bad++;
          $display("FAIL %s acc%0d cycle %0d: got %0d expected %0d", name, d, c, acc[d], ea);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    step();
    total++;
    if (obs_now() !== out_t'(0)) begin
      bad++;
      $display("FAIL reset_held: got %h expected 0", obs_now());
    end
    start = 1'b0;
    rst   = 1'b0;
    step();
    total++;
    if (obs_now() !== out_t'(0)) begin
      bad++;
      $display("FAIL reset_released: got %h expected 0", obs_now());
    end
  endtask

  task automatic test_nominal();
    int n_rd = 0, n_we = 0, n_fe = 0, n_ae = 0;
    do_reset();
    load_nominal();
    run_checked_frame("nominal");
    exp_q.push_back(32'd37);
    exp_q.push_back(32'd47);
    exp_q.push_back(32'd67);
    exp_q.push_back(32'd77);
    for (int d = 0; d < 4; d++) begin
      logic [31:0] x;
      x = exp_q.pop_front();
      total++;
      if (acc[d] !== x) begin
        bad++;
        $display("FAIL nominal_result c%0d: got %0d expected %0d", d, acc[d], x);
      end
    end
    // Second pass over the same frame just counting pulses.
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      step();
      start = 1'b0;
      n_rd += int'(mem_rd_en);
      n_we += $countones(weight_en);
      n_fe += $countones(feature_en);
      n_ae += $countones(acc_en);
    end
    total++;
    if ({n_rd, n_we, n_fe, n_ae} !== {32'd20, 32'd4, 32'd16, 32'd4}) begin
      bad++;
      $display("FAIL pulse_counts: got rd=%0d we=%0d fe=%0d ae=%0d expected 20/4/16/4", n_rd, n_we, n_fe, n_ae);
    end
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      load_random();
      run_checked_frame("random");
      for (int d = 0; d < 4; d++) exp_q.push_back(conv(d));
      for (int d = 0; d < 4; d++) begin
        logic [31:0] x;
        x = exp_q.pop_front();
        total++;
        if (acc[d] !== x) begin
          bad++;
          $display("FAIL random_result it%0d c%0d: got %0d expected %0d", it, d, acc[d], x);
        end
      end
    end
  endtask

  task automatic test_start_held();
    out_t e;
    out_t ob;
    do_reset();
    load_random();
    start = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      step();
      e  = (c <= 30) ? exp_out(c) : exp_out(c - 30);
      ob = obs_now();
      total++;
      if (ob !== e) begin
        bad++;
        $display("FAIL start_held cycle %0d: got %h expected %h", c, ob, e);
      end
    end
    total++;
    if (acc[0] !== 2 * conv(0) || acc[1] !== conv(1)) begin
      bad++;
      $display("FAIL start_held_acc: got c11=%0d c12=%0d expected %0d %0d", acc[0], acc[1], 2 * conv(0), conv(1));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    total++;
    if (obs_now() !== out_t'(0)) begin
      bad++;
      $display("FAIL start_held_abort: got %h expected 0", obs_now());
    end
  endtask

  task automatic test_abort(int a, logic nominal);
    out_t        e;
    out_t        ob;
    logic [31:0] ea;
    do_reset();
    if (nominal) load_nominal();
    else         load_random();
    start = 1'b1;
    for (int c = 1; c <= a + 30; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (c == a + 1) abort = 1'b0;
      e  = (c <= a) ? exp_out(c) : out_t'(0);
      ob = obs_now();
      total++;
      if (ob !== e) begin
        bad++;
        $display("FAIL abort_at_%0d cycle %0d: got %h expected %h", a, c, ob, e);
      end
      if (c == a) abort = 1'b1;
    end
    for (int d = 0; d < 4; d++) begin
      ea = (10 + 6*d <= a) ? conv(d) : 32'd0;
      total++;
      if (acc[d] !== ea) begin
        bad++;
        $display("FAIL abort_at_%0d acc%0d: got %0d expected %0d", a, d, acc[d], ea);
      end
    end
  endtask

  task automatic test_async_rst();
    do_reset();
    load_nominal();
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      start = 1'b0;
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (obs_now() !== out_t'(0)) begin
      bad++;
      $display("FAIL async_rst_outputs: got %h expected 0", obs_now());
    end
    total++;
    if (acc[0] !== 32'd0 || acc[1] !== 32'd0) begin
      bad++;
      $display("FAIL async_rst_acc: got c11=%0d c12=%0d expected 0 0", acc[0], acc[1]);
    end
    step();
    rst = 1'b0;
    step();
    run_checked_frame("after_rst");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int n = 0; n < 256; n++) mem[n] = 8'($urandom_range(0, 255));
    test_reset();
    test_nominal();
    test_random_frames();
    test_start_held();
    test_abort(12, 1'b1);
    test_abort(1, 1'b0);
    test_abort(29, 1'b0);
    for (int it = 0; it < 3; it++) test_abort(int'($urandom_range(1, 29)), 1'b0);
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
